phase_sequencer: RTL and testbench
==================================

# phase_sequencer

Consumer end of the three-phase CPU clocking scheme: samples the one-hot phase strobes `cycle_clk`, `ram_clk` and `internal_clk` as enables in the `clk` domain. It checks their order and tracks the instruction micro-step (T-state). It emits single-cycle action pulses to the datapath and returns `halt` to the phase generator so that a HLT stops the clock on a machine-cycle boundary. It sits between the phase generator and the control/decode logic.

## Interface
- `STEP_W`, 3: width of `step`.
- `MAX_STEPS`, 6: number of T-states per instruction; `step` wraps after `MAX_STEPS-1`. Legal range 2..2^STEP_W.
- `CNT_W`, 16: width of `mcycle_count`.

Ports:
- `clk` in 1: system clock. Rising edge only.
- `reset` in 1: synchronous, active-high reset.
- `cycle_clk` in 1: phase A strobe from the phase generator.
- `ram_clk` in 1: phase B strobe.
- `internal_clk` in 1: phase C strobe.
- `hlt_req` in 1: halt request from the decoder. Level-sampled.
- `resume` in 1: clears an active halt.
- `step_clr` in 1: end-of-instruction from the decoder. Sampled with the accepted `internal_clk` strobe.
- `cycle_start` out 1: pulse on an accepted phase A.
- `mem_strobe` out 1: pulse on an accepted phase B.
- `exec_strobe` out 1: pulse on an accepted phase C.
- `step` out STEP_W: current T-state.
- `mcycle_count` out CNT_W: completed machine cycles, mod 2^CNT_W.
- `halt` out 1: to the phase generator's halt input.
- `phase_err` out 1: sticky protocol-violation flag.

## Operation
- Strobe vector is {`cycle_clk`,`ram_clk`,`internal_clk`}.
  - All-zero is a legal gap in any state and causes no action.
  - A vector with more than one bit set is a violation in every state.
- FSM states: SYNC, EXP_A, EXP_B, EXP_C, ERROR. Reset enters SYNC.
  - SYNC: phase A goes to EXP_B and counts as accepted. Phase B and phase C are ignored; the generator's phase after reset is arbitrary.
  - EXP_B: phase B goes to EXP_C. Phase A or phase C goes to ERROR.
  - EXP_C: phase C goes to EXP_A. Phase A or phase B goes to ERROR.
  - EXP_A: phase A goes to EXP_B. Phase B or phase C goes to ERROR.
  - ERROR: absorbing. Only `reset` exits.
- Accepted phase C ends the machine cycle:
  - `mcycle_count` += 1, wrapping at 2^CNT_W.
  - `step` becomes 0 if `step_clr`=1 or `step`==MAX_STEPS-1; otherwise `step`+1.
- Halt control:
  - `hlt_req`=1 in any cycle sets an internal `halt_pend` flag.
  - An accepted phase C with `halt_pend` set (including `hlt_req` in that same cycle) sets `halt`=1 and clears `halt_pend`.
  - `halt` is never asserted mid-cycle, i.e. in EXP_B or EXP_C.
  - `resume`=1 while `halt`=1 clears `halt`.
  - `resume` and `hlt_req` high in the same cycle: `halt` clears and `halt_pend` sets, so the CPU re-halts at the end of the next machine cycle.
  - `resume` while `halt`=0 has no effect.
- ERROR behaviour:
  - `phase_err`=1.
  - `cycle_start`, `mem_strobe` and `exec_strobe` are held at 0.
  - `step` and `mcycle_count` freeze.
  - `halt` is forced to 1 to stop the clock.
- Reset values: `step`=0, `mcycle_count`=0, all pulse outputs 0, `halt`=0, `phase_err`=0, `halt_pend`=0, state SYNC.
- Reset mid-cycle discards any partial machine cycle. `reset` overrides every other input in the same cycle.

## Timing
- All outputs are registered.
- Each pulse is high for exactly one `clk` cycle, in the cycle after the strobe is sampled (latency 1).
- `step` and `mcycle_count` update in the same cycle as `exec_strobe` rises.
- `halt` rises in the same cycle as the final `exec_strobe`. The generator, which outputs zeros while halted, therefore emits no further phase.
- `halt` falls 1 cycle after `resume` is sampled.
- `phase_err` and forced `halt` rise 1 cycle after the violating vector is sampled.
- Back-to-back strobes (A, B, C on consecutive clocks) are sustained with no bubbles. Gaps of any length between phases are tolerated.

## Test plan
- Reset, then repeat A,B,C for 7 machine cycles: `step` goes 1,2,3,4,5,0,1; `mcycle_count`=7; each pulse occurs once per cycle; `phase_err`=0.
- After reset, drive C,A,B,C (generator starting mid-sequence): first C ignored; one machine cycle counted; `step`=1.
- Raise `hlt_req` for one cycle during phase B: `halt`=1 together with the following `exec_strobe`, not earlier. Then assert `resume`: `halt`=0 one cycle later and the sequence continues from phase A.
- Assert `step_clr` with phase C while `step`=2: `step`=0 next cycle; `mcycle_count` still increments.
- Drive A then C (skipping B): `phase_err`=1 and `halt`=1 one cycle later. Further valid strobes produce no pulses and `step` stays frozen. `reset` clears everything.
- Drive vector 3'b110 in EXP_A, and separately preload `mcycle_count` to 0xFFFF and complete one cycle: the first gives ERROR; the second wraps `mcycle_count` to 0x0000.

Source files
------------

// File: rtl/phase_sequencer.sv
// phase_sequencer: consumer side of the three-phase clocking scheme.
// Treats the phase strobes as clk-domain enables, checks their A->B->C
// order, tracks the T-state, emits one-cycle action pulses and returns
// halt to the phase generator so HLT stops on a machine-cycle boundary.
module phase_sequencer #(
   parameter int STEP_W    = 3,
   parameter int MAX_STEPS = 6,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cycle_clk,
   input  logic              ram_clk,
   input  logic              internal_clk,
   input  logic              hlt_req,
   input  logic              resume,
   input  logic              step_clr,
   output logic              cycle_start,
   output logic              mem_strobe,
   output logic              exec_strobe,
   output logic [STEP_W-1:0] step,
   output logic [CNT_W-1:0]  mcycle_count,
   output logic              halt,
   output logic              phase_err
);

   typedef enum logic [2:0] {
      ST_SYNC  = 3'd0,
      ST_EXP_A = 3'd1,
      ST_EXP_B = 3'd2,
      ST_EXP_C = 3'd3,
      ST_ERROR = 3'd4
   } state_t;

   localparam logic [2:0] VEC_NONE = 3'b000;
   localparam logic [2:0] VEC_A    = 3'b100;
   localparam logic [2:0] VEC_B    = 3'b010;
   localparam logic [2:0] VEC_C    = 3'b001;

   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEPS - 1);

   state_t            state_r;
   state_t            state_nxt_s;
   logic [2:0]        vec_s;
   logic              multi_s;
   logic              accept_a_s;
   logic              accept_b_s;
   logic              accept_c_s;

   logic              cycle_start_r;
   logic              mem_strobe_r;
   logic              exec_strobe_r;
   logic [STEP_W-1:0] step_r;
   logic [CNT_W-1:0]  mcycle_count_r;
   logic              halt_r;
   logic              halt_pend_r;
   logic              phase_err_r;

   logic [STEP_W-1:0] step_nxt_s;
   logic [CNT_W-1:0]  mcycle_count_nxt_s;
   logic              halt_nxt_s;
   logic              halt_pend_nxt_s;
   logic              pend_eff_s;

   assign vec_s   = {cycle_clk, ram_clk, internal_clk};
   // More than one strobe high at once is never a legal phase.
   assign multi_s = (cycle_clk & ram_clk) | (cycle_clk & internal_clk) |
                    (ram_clk & internal_clk);

   // State register: reset returns to SYNC, discarding any partial cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_SYNC;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic: order check and acceptance of the expected phase.
   always_comb begin
      state_nxt_s = state_r;
      accept_a_s  = 1'b0;
      accept_b_s  = 1'b0;
      accept_c_s  = 1'b0;
      case (state_r)
         ST_SYNC: begin
            // Generator phase after reset is arbitrary: wait for the first A.
            if (multi_s) begin
               state_nxt_s = ST_ERROR;
            end else if (vec_s == VEC_A) begin
               state_nxt_s = ST_EXP_B;
               accept_a_s  = 1'b1;
            end else begin
               state_nxt_s = ST_SYNC;
            end
         end
         ST_EXP_A: begin
            if (vec_s == VEC_NONE) begin
               state_nxt_s = ST_EXP_A;
            end else if (vec_s == VEC_A) begin
               state_nxt_s = ST_EXP_B;
               accept_a_s  = 1'b1;
            end else begin
               state_nxt_s = ST_ERROR;
            end
         end
         ST_EXP_B: begin
            if (vec_s == VEC_NONE) begin
               state_nxt_s = ST_EXP_B;
            end else if (vec_s == VEC_B) begin
               state_nxt_s = ST_EXP_C;
               accept_b_s  = 1'b1;
            end else begin
               state_nxt_s = ST_ERROR;
            end
         end
         ST_EXP_C: begin
            if (vec_s == VEC_NONE) begin
               state_nxt_s = ST_EXP_C;
            end else if (vec_s == VEC_C) begin
               state_nxt_s = ST_EXP_A;
               accept_c_s  = 1'b1;
            end else begin
               state_nxt_s = ST_ERROR;
            end
         end
         ST_ERROR: begin
            state_nxt_s = ST_ERROR;
         end
         default: begin
            state_nxt_s = ST_ERROR;
         end
      endcase
   end

   // Output logic: T-state, cycle counter and halt handshake next values.
   always_comb begin
      step_nxt_s         = step_r;
      mcycle_count_nxt_s = mcycle_count_r;
      halt_nxt_s         = halt_r;
      halt_pend_nxt_s    = halt_pend_r;
      pend_eff_s         = halt_pend_r | hlt_req;

      if (accept_c_s) begin
         mcycle_count_nxt_s = mcycle_count_r + CNT_W'(1);
         if (step_clr || (step_r == STEP_LAST)) begin
            step_nxt_s = {STEP_W{1'b0}};
         end else begin
            step_nxt_s = step_r + STEP_W'(1);
         end
      end else begin
         mcycle_count_nxt_s = mcycle_count_r;
         step_nxt_s         = step_r;
      end

      // Halt only takes effect at the end of a machine cycle; a request
      // arriving together with resume re-arms for the next cycle end.
      if (accept_c_s && pend_eff_s) begin
         halt_nxt_s      = 1'b1;
         halt_pend_nxt_s = 1'b0;
      end else if (halt_r && resume) begin
         halt_nxt_s      = 1'b0;
         halt_pend_nxt_s = pend_eff_s;
      end else begin
         halt_nxt_s      = halt_r;
         halt_pend_nxt_s = pend_eff_s;
      end

      // A protocol violation stops the clock regardless of the handshake.
      if (state_nxt_s == ST_ERROR) begin
         halt_nxt_s = 1'b1;
      end else begin
         halt_nxt_s = halt_nxt_s;
      end
   end

   // Output registers: every output is driven from a flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_start_r  <= 1'b0;
         mem_strobe_r   <= 1'b0;
         exec_strobe_r  <= 1'b0;
         step_r         <= {STEP_W{1'b0}};
         mcycle_count_r <= {CNT_W{1'b0}};
         halt_r         <= 1'b0;
         halt_pend_r    <= 1'b0;
         phase_err_r    <= 1'b0;
      end else begin
         cycle_start_r  <= accept_a_s;
         mem_strobe_r   <= accept_b_s;
         exec_strobe_r  <= accept_c_s;
         step_r         <= step_nxt_s;
         mcycle_count_r <= mcycle_count_nxt_s;
         halt_r         <= halt_nxt_s;
         halt_pend_r    <= halt_pend_nxt_s;
         phase_err_r    <= (state_nxt_s == ST_ERROR);
      end
   end

   assign cycle_start  = cycle_start_r;
   assign mem_strobe   = mem_strobe_r;
   assign exec_strobe  = exec_strobe_r;
   assign step         = step_r;
   assign mcycle_count = mcycle_count_r;
   assign halt         = halt_r;
   assign phase_err    = phase_err_r;

endmodule

// File: tb/tb_phase_sequencer.sv
// Testbench for phase_sequencer: directed scenarios plus randomized
// strobe streams, every cycle compared against a behavioural model.
// A 10-bit cycle counter is used so the counter wrap is reachable quickly.
module tb_phase_sequencer;

   localparam int STEP_W    = 3;
   localparam int MAX_STEPS = 6;
   localparam int CNT_W     = 10;

   localparam logic [2:0] V0 = 3'b000;
   localparam logic [2:0] VA = 3'b100;
   localparam logic [2:0] VB = 3'b010;
   localparam logic [2:0] VC = 3'b001;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              cycle_clk = 1'b0;
   logic              ram_clk = 1'b0;
   logic              internal_clk = 1'b0;
   logic              hlt_req = 1'b0;
   logic              resume = 1'b0;
   logic              step_clr = 1'b0;
   logic              cycle_start;
   logic              mem_strobe;
   logic              exec_strobe;
   logic [STEP_W-1:0] step;
   logic [CNT_W-1:0]  mcycle_count;
   logic              halt;
   logic              phase_err;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: phase order as "which phase index (0=A,1=B,2=C)
   // comes next", plus plain integer counters.
   bit m_synced, m_err, m_halt, m_pend, m_cs, m_ms, m_es;
   int m_next, m_step, m_cnt;

   phase_sequencer #(.STEP_W(STEP_W), .MAX_STEPS(MAX_STEPS), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .cycle_clk(cycle_clk), .ram_clk(ram_clk), .internal_clk(internal_clk),
      .hlt_req(hlt_req), .resume(resume), .step_clr(step_clr),
      .cycle_start(cycle_start), .mem_strobe(mem_strobe), .exec_strobe(exec_strobe),
      .step(step), .mcycle_count(mcycle_count), .halt(halt), .phase_err(phase_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_synced = 1'b0; m_err = 1'b0; m_halt = 1'b0; m_pend = 1'b0;
      m_cs = 1'b0; m_ms = 1'b0; m_es = 1'b0;
      m_next = 0; m_step = 0; m_cnt = 0;
   endtask

   // Apply one clock edge of the specification's rules to the model.
   task automatic model_edge();
      logic [2:0] v;
      int p;
      bit pend_eff;
      v = {cycle_clk, ram_clk, internal_clk};
      if (reset) begin
         model_reset();
      end else begin
         m_cs = 1'b0; m_ms = 1'b0; m_es = 1'b0;
         if (!m_err && $countones(v) > 1) begin
            m_err = 1'b1;
         end else if (!m_err && $countones(v) == 1) begin
            p = (v == VA) ? 0 : (v == VB) ? 1 : 2;
            if (!m_synced) begin
               if (p == 0) begin
                  m_synced = 1'b1; m_cs = 1'b1; m_next = 1;
               end
            end else if (p == m_next) begin
               m_next = (p + 1) % 3;
               if (p == 0) m_cs = 1'b1;
               else if (p == 1) m_ms = 1'b1;
               else m_es = 1'b1;
            end else begin
               m_err = 1'b1;
            end
         end
         pend_eff = m_pend | hlt_req;
         if (m_es) begin
            m_cnt  = (m_cnt + 1) % (1 << CNT_W);
            m_step = (step_clr || m_step == MAX_STEPS - 1) ? 0 : m_step + 1;
         end
         if (m_es && pend_eff) begin
            m_halt = 1'b1; m_pend = 1'b0;
         end else if (m_halt && resume) begin
            m_halt = 1'b0; m_pend = pend_eff;
         end else begin
            m_pend = pend_eff;
         end
         if (m_err) m_halt = 1'b1;
      end
   endtask

   task automatic check_all();
      check_eq("cycle_start",  32'(cycle_start),  32'(m_cs));
      check_eq("mem_strobe",   32'(mem_strobe),   32'(m_ms));
      check_eq("exec_strobe",  32'(exec_strobe),  32'(m_es));
      check_eq("step",         32'(step),         32'(m_step));
      check_eq("mcycle_count", 32'(mcycle_count), 32'(m_cnt));
      check_eq("halt",         32'(halt),         32'(m_halt));
      check_eq("phase_err",    32'(phase_err),    32'(m_err));
   endtask

   // One clock: drive inputs away from the edge, update the model, check.
   task automatic tick(input logic [2:0] vec, input logic hr = 1'b0,
                       input logic rs = 1'b0, input logic sc = 1'b0,
                       input logic rst = 1'b0);
      {cycle_clk, ram_clk, internal_clk} = vec;
      hlt_req = hr; resume = rs; step_clr = sc; reset = rst;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic abc(input int n);
      for (int i = 0; i < n; i++) begin
         tick(VA); tick(VB); tick(VC);
      end
   endtask

   initial begin
      logic [2:0] v;
      int gen_ph;
      model_reset();

      // Reset state.
      tick(V0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("rst_step", 32'(step), 32'd0);
      check_eq("rst_halt", 32'(halt), 32'd0);

      // Seven back-to-back machine cycles.
      abc(7);
      check_eq("seq7_step", 32'(step), 32'd1);
      check_eq("seq7_cnt", 32'(mcycle_count), 32'd7);
      check_eq("seq7_err", 32'(phase_err), 32'd0);

      // Generator starting mid-sequence: leading C is ignored.
      tick(V0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(VC); tick(V0); tick(VA); tick(VB); tick(V0); tick(V0); tick(VC);
      check_eq("mid_cnt", 32'(mcycle_count), 32'd1);
      check_eq("mid_step", 32'(step), 32'd1);

      // Halt request during B, halt with the closing exec_strobe, then resume.
      tick(VA); tick(VB, 1'b1);
      check_eq("hlt_early", 32'(halt), 32'd0);
      tick(VC);
      check_eq("hlt_rise", 32'(halt), 32'd1);
      check_eq("hlt_exec", 32'(exec_strobe), 32'd1);
      tick(V0); tick(V0, 1'b0, 1'b1);
      check_eq("resume_fall", 32'(halt), 32'd0);
      tick(VA);
      check_eq("resume_a", 32'(cycle_start), 32'd1);
      tick(VB); tick(VC);

      // step_clr with C while step==2.
      tick(V0, 1'b0, 1'b0, 1'b0, 1'b1);
      abc(2);
      tick(VA); tick(VB); tick(VC, 1'b0, 1'b0, 1'b1);
      check_eq("clr_step", 32'(step), 32'd0);
      check_eq("clr_cnt", 32'(mcycle_count), 32'd3);

      // Skipped B: error, halt forced, outputs frozen, reset recovers.
      tick(V0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(VA); tick(VC);
      check_eq("skip_err", 32'(phase_err), 32'd1);
      check_eq("skip_halt", 32'(halt), 32'd1);
      tick(VA); tick(VB); tick(VC, 1'b0, 1'b1); tick(VA);
      check_eq("err_step", 32'(step), 32'd0);
      check_eq("err_halt", 32'(halt), 32'd1);
      tick(V0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("rec_err", 32'(phase_err), 32'd0);
      check_eq("rec_halt", 32'(halt), 32'd0);

      // Double strobe in EXP_A.
      abc(1);
      tick(3'b110);
      check_eq("multi_err", 32'(phase_err), 32'd1);

      // Counter wrap at 2^CNT_W machine cycles.
      tick(V0, 1'b0, 1'b0, 1'b0, 1'b1);
      abc((1 << CNT_W) - 1);
      check_eq("wrap_pre", 32'(mcycle_count), 32'((1 << CNT_W) - 1));
      abc(1);
      check_eq("wrap_cnt", 32'(mcycle_count), 32'd0);
      check_eq("wrap_step", 32'(step), 32'(((1 << CNT_W) % MAX_STEPS)));

      // Randomized generator-like stream with occasional faults and resets.
      tick(V0, 1'b0, 1'b0, 1'b0, 1'b1);
      gen_ph = $urandom_range(0, 2);
      for (int i = 0; i < 4000; i++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 60 && (!halt || $urandom_range(0, 9) == 0)) begin
            v = (gen_ph == 0) ? VA : (gen_ph == 1) ? VB : VC;
            gen_ph = (gen_ph + 1) % 3;
         end else if (r < 95) begin
            v = V0;
         end else begin
            v = 3'($urandom_range(0, 7));
         end
         tick(v, 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) == 0),
              1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 199) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
